// File: rtl/iir_cfg_ctrl.sv
// Coefficient sequencer in front of a first-order IIR filter: shadow/active
// coefficient banks, sample gating, in-flight tracking and drain-then-swap.
module iir_cfg_ctrl #(
    parameter int NB       = 12,
    parameter int MAX_INFL = 4,
    parameter int DRAIN_TO = 64
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cfg_we,
    input  logic [1:0]    i_cfg_addr,
    input  logic [NB-1:0] i_cfg_data,
    input  logic          i_cfg_commit,
    input  logic [NB-1:0] i_din,
    input  logic          i_vin,
    output logic          o_din_rdy,
    output logic [NB-1:0] o_f_din,
    output logic          o_f_vin,
    output logic [NB-1:0] o_b0,
    output logic [NB-1:0] o_b1,
    output logic [NB-1:0] o_a1,
    input  logic          i_f_vout,
    output logic          o_flt_clr,
    output logic          o_busy,
    output logic          o_err,
    output logic [7:0]    o_swap_cnt
);
    localparam int IW = $clog2(MAX_INFL + 1);
    localparam int TW = (DRAIN_TO > 1) ? $clog2(DRAIN_TO) : 1;
    localparam logic [IW:0]   INFL_LIMIT = (IW+1)'(MAX_INFL);
    localparam logic [TW-1:0] TO_LAST    = TW'(DRAIN_TO - 1);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_SWAP, S_CLEAR} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [NB-1:0] r_sh_b0, r_sh_b1, r_sh_a1;
    logic          r_clr_en;
    logic [NB-1:0] r_b0, r_b1, r_a1;
    logic [NB-1:0] r_f_din;
    logic          r_f_vin;
    logic [IW-1:0] r_infl;
    logic          r_pending;
    logic [TW-1:0] r_to;
    logic          r_err;
    logic [7:0]    r_swap_cnt;
    logic [IW:0]   w_infl_eff;
    logic          w_accept;
    logic          w_drained;
    logic          w_timeout;

    // The registered F_VIN is already committed to the filter, so it counts
    // against the in-flight limit before the counter itself sees it.
    assign w_infl_eff = {1'b0, r_infl} + {{IW{1'b0}}, r_f_vin};
    assign o_din_rdy  = (r_state == S_RUN) && (w_infl_eff < INFL_LIMIT) && !i_rst;
    assign w_accept   = i_vin && o_din_rdy;
    assign w_drained  = (r_infl == '0) && !r_f_vin;
    assign w_timeout  = (r_state == S_DRAIN) && !w_drained && (r_to == TO_LAST);

    assign o_f_din    = r_f_din;
    assign o_f_vin    = r_f_vin;
    assign o_b0       = r_b0;
    assign o_b1       = r_b1;
    assign o_a1       = r_a1;
    assign o_err      = r_err;
    assign o_swap_cnt = r_swap_cnt;

    always_comb begin
        w_state_next = r_state;
        o_busy       = (r_state != S_RUN);
        o_flt_clr    = (r_state == S_CLEAR);
        case (r_state)
            S_RUN:   if (i_cfg_commit || r_pending) w_state_next = S_DRAIN;
            S_DRAIN: if (w_drained || w_timeout) w_state_next = S_SWAP;
            S_SWAP:  w_state_next = r_clr_en ? S_CLEAR : S_RUN;
            S_CLEAR: w_state_next = S_RUN;
            default: w_state_next = S_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_RUN;
            r_sh_b0    <= '0;
            r_sh_b1    <= '0;
            r_sh_a1    <= '0;
            r_clr_en   <= 1'b0;
            r_b0       <= '0;
            r_b1       <= '0;
            r_a1       <= '0;
            r_f_din    <= '0;
            r_f_vin    <= 1'b0;
            r_infl     <= '0;
            r_pending  <= 1'b0;
            r_to       <= '0;
            r_err      <= 1'b0;
            r_swap_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (i_cfg_we) begin
                case (i_cfg_addr)
                    2'd0:    r_sh_b0  <= i_cfg_data;
                    2'd1:    r_sh_b1  <= i_cfg_data;
                    2'd2:    r_sh_a1  <= i_cfg_data;
                    default: r_clr_en <= i_cfg_data[0];
                endcase
            end
            r_f_vin <= w_accept;
            if (w_accept) r_f_din <= i_din;
            // A commit seen in RUN starts the drain directly; elsewhere it is remembered.
            if (r_state == S_RUN) r_pending <= 1'b0;
            else if (i_cfg_commit) r_pending <= 1'b1;
            r_to <= (r_state == S_DRAIN) ? r_to + TW'(1) : '0;
            if (r_state == S_SWAP) r_infl <= '0;
            else if (r_f_vin && !i_f_vout) r_infl <= r_infl + IW'(1);
            else if (!r_f_vin && i_f_vout && (r_infl != '0)) r_infl <= r_infl - IW'(1);
            if (w_timeout || (i_f_vout && (r_infl == '0))) r_err <= 1'b1;
            if (r_state == S_SWAP) begin
                r_b0       <= r_sh_b0;
                r_b1       <= r_sh_b1;
                r_a1       <= r_sh_a1;
                r_swap_cnt <= r_swap_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_iir_cfg_ctrl.sv
// Scoreboard bench for iir_cfg_ctrl: directed stimulus pushes expected samples
// and coefficient swaps into queues, a negedge monitor pops and compares.
module tb_iir_cfg_ctrl;
    localparam int NB = 12;

    typedef struct {
        logic [NB-1:0] b0;
        logic [NB-1:0] b1;
        logic [NB-1:0] a1;
        logic [7:0]    cnt;
        logic          drained;
    } coef_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfgWe = 1'b0;
    logic [1:0]    cfgAddr = '0;
    logic [NB-1:0] cfgData = '0;
    logic          cfgCommit = 1'b0;
    logic [NB-1:0] din = '0;
    logic          vin = 1'b0;
    logic          voutMan = 1'b0;
    logic          modelEn = 1'b0;
    logic          pipe0 = 1'b0, pipe1 = 1'b0, fvSeen = 1'b0;
    logic          fVout;
    logic          dinRdy, fVin, fltClr, busy, err;
    logic [NB-1:0] fDin, b0, b1, a1;
    logic [7:0]    swapCnt;

    logic [NB-1:0] sampQ[$];
    coef_t         coefQ[$];
    int            checks = 0, errors = 0;
    int            acceptCnt = 0, outCnt = 0, fltCnt = 0, benchInfl = 0;
    logic [7:0]    lastCnt = '0;
    logic          prevBusy = 1'b0;
    int            acc0, outBase, busyCycles;
    logic          doCommit, prevCommit, committed;
    logic [NB-1:0] dv;

    assign fVout = voutMan | (modelEn & pipe1);

    iir_cfg_ctrl #(.NB(NB), .MAX_INFL(4), .DRAIN_TO(64)) dut (
        .i_clk(clk), .i_rst(rst), .i_cfg_we(cfgWe), .i_cfg_addr(cfgAddr),
        .i_cfg_data(cfgData), .i_cfg_commit(cfgCommit), .i_din(din), .i_vin(vin),
        .o_din_rdy(dinRdy), .o_f_din(fDin), .o_f_vin(fVin), .o_b0(b0), .o_b1(b1),
        .o_a1(a1), .i_f_vout(fVout), .o_flt_clr(fltClr), .o_busy(busy),
        .o_err(err), .o_swap_cnt(swapCnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [NB-1:0] d,
                                 input logic w, input logic [1:0] a, input logic [NB-1:0] cd,
                                 input logic c, input logic vo);
        @(posedge clk);
        #1;
        rst = r; vin = v; din = d; cfgWe = w; cfgAddr = a; cfgData = cd;
        cfgCommit = c; voutMan = vo;
        #1;
        if (v && dinRdy) begin
            sampQ.push_back(d);
            acceptCnt++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, 2'd0, '0, 0, 0);
    endtask

    task automatic writeCfg(input logic [1:0] a, input logic [NB-1:0] d);
        applyStimulus(0, 0, '0, 1, a, d, 0, 0);
    endtask

    task automatic expectSwap(input logic [NB-1:0] eb0, input logic [NB-1:0] eb1,
                              input logic [NB-1:0] ea1, input logic [7:0] ecnt, input logic dr);
        coef_t e;
        e.b0 = eb0; e.b1 = eb1; e.a1 = ea1; e.cnt = ecnt; e.drained = dr;
        coefQ.push_back(e);
    endtask

    // Two-cycle-latency filter stand-in: F_VOUT follows F_VIN by two cycles.
    always @(negedge clk) fvSeen = fVin;
    always @(posedge clk) begin
        #1;
        pipe1 = pipe0;
        pipe0 = fvSeen & modelEn;
    end

    always @(negedge clk) begin
        coef_t e;
        if (rst) begin
            benchInfl = 0;
        end else begin
            if (swapCnt != lastCnt && swapCnt == lastCnt + 8'd1) begin
                if (coefQ.size() == 0) begin
                    checkOutput("unexpected_swap", {56'd0, swapCnt}, {56'd0, lastCnt});
                end else begin
                    e = coefQ.pop_front();
                    checkOutput("swap_b0", b0, e.b0);
                    checkOutput("swap_b1", b1, e.b1);
                    checkOutput("swap_a1", a1, e.a1);
                    checkOutput("swap_cnt", swapCnt, e.cnt);
                    if (e.drained) checkOutput("drained_before_swap", benchInfl, 0);
                    else benchInfl = 0;
                end
            end
            checkOutput("fvin_while_busy", fVin & busy & prevBusy, 0);
            if (fVin) begin
                if (sampQ.size() == 0) checkOutput("f_vin_unexpected", 1, 0);
                else checkOutput("f_din", fDin, sampQ.pop_front());
                outCnt++;
                benchInfl++;
            end
            if (fVout && benchInfl > 0) benchInfl--;
        end
        if (fltClr) fltCnt++;
        lastCnt  = swapCnt;
        prevBusy = busy;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset state and a swap with the filter idle.
        applyStimulus(1, 0, '0, 0, 2'd0, '0, 0, 0);
        checkOutput("rdy_in_reset", dinRdy, 0);
        idle(1);
        checkOutput("reset_coefs", {b0, b1, a1}, 0);
        checkOutput("reset_flags", {fVin, fltClr, busy, err}, 0);
        checkOutput("reset_swapcnt", swapCnt, 0);
        checkOutput("reset_rdy", dinRdy, 1);
        writeCfg(2'd0, 12'h100);
        writeCfg(2'd1, 12'h080);
        writeCfg(2'd2, 12'hF00);
        checkOutput("t1_no_early_swap", b0, 0);
        expectSwap(12'h100, 12'h080, 12'hF00, 8'd1, 1'b1);
        applyStimulus(0, 0, '0, 0, 2'd0, '0, 1, 0);
        checkOutput("t1_busy_commit", busy, 0);
        idle(1);
        checkOutput("t1_busy_drain", {busy, b0}, {1'b1, 12'h000});
        idle(1);
        checkOutput("t1_busy_swap", {busy, b0}, {1'b1, 12'h000});
        idle(1);
        checkOutput("t1_run_after", {busy, b0, b1, a1}, {1'b0, 12'h100, 12'h080, 12'hF00});
        checkOutput("t1_swapcnt", swapCnt, 1);
        checkOutput("t1_no_fltclr", fltCnt, 0);

        // Continuous stream through a two-cycle filter with a mid-stream commit.
        writeCfg(2'd0, 12'h111);
        writeCfg(2'd1, 12'h222);
        writeCfg(2'd2, 12'h333);
        expectSwap(12'h111, 12'h222, 12'h333, 8'd2, 1'b1);
        modelEn = 1'b1;
        acc0 = acceptCnt; outBase = outCnt; committed = 1'b0; prevCommit = 1'b0;
        for (int g = 0; g < 100 && (acceptCnt - acc0) < 20; g++) begin
            doCommit = !committed && ((acceptCnt - acc0) == 8);
            dv = NB'(12'h200 + (acceptCnt - acc0));
            applyStimulus(0, 1, dv, 0, 2'd0, '0, doCommit, 0);
            if (prevCommit) checkOutput("t2_rdy_after_commit", dinRdy, 0);
            if (doCommit) begin
                checkOutput("t2_rdy_commit_cycle", dinRdy, 1);
                committed = 1'b1;
            end
            prevCommit = doCommit;
        end
        idle(8);
        modelEn = 1'b0;
        checkOutput("t2_accepts", acceptCnt - acc0, 20);
        checkOutput("t2_outputs", outCnt - outBase, 20);
        checkOutput("t2_swapcnt", swapCnt, 2);

        // Clear-enable: one FLT_CLR pulse right after SWAP.
        writeCfg(2'd3, 12'h001);
        expectSwap(12'h111, 12'h222, 12'h333, 8'd3, 1'b1);
        applyStimulus(0, 0, '0, 0, 2'd0, '0, 1, 0);
        idle(1);
        checkOutput("t3_flt_drain", fltClr, 0);
        idle(1);
        checkOutput("t3_flt_swap", fltClr, 0);
        idle(1);
        checkOutput("t3_flt_clear", {fltClr, dinRdy}, 2'b10);
        idle(1);
        checkOutput("t3_flt_run", {fltClr, dinRdy}, 2'b01);
        checkOutput("t3_flt_count", fltCnt, 1);
        writeCfg(2'd3, 12'h000);

        // Second commit plus a b0 write during DRAIN.
        writeCfg(2'd0, 12'h0AA);
        expectSwap(12'h055, 12'h222, 12'h333, 8'd4, 1'b1);
        expectSwap(12'h055, 12'h222, 12'h333, 8'd5, 1'b1);
        modelEn = 1'b1;
        applyStimulus(0, 1, 12'h301, 0, 2'd0, '0, 0, 0);
        applyStimulus(0, 1, 12'h302, 0, 2'd0, '0, 1, 0);
        applyStimulus(0, 0, '0, 0, 2'd0, '0, 0, 0);
        checkOutput("t5_in_drain", busy, 1);
        applyStimulus(0, 0, '0, 1, 2'd0, 12'h055, 1, 0);
        idle(12);
        modelEn = 1'b0;
        checkOutput("t5_swapcnt", swapCnt, 5);
        checkOutput("t5_b0", b0, 12'h055);
        checkOutput("t5_idle", {busy, fltCnt[3:0]}, {1'b0, 4'd1});

        // Drain timeout with three samples stuck in the filter.
        writeCfg(2'd0, 12'h0A0);
        writeCfg(2'd1, 12'h0B0);
        writeCfg(2'd2, 12'h0C0);
        expectSwap(12'h0A0, 12'h0B0, 12'h0C0, 8'd6, 1'b0);
        checkOutput("t4_err_before", err, 0);
        acc0 = acceptCnt;
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, NB'(12'h401 + i), 0, 2'd0, '0, 0, 0);
        checkOutput("t4_accepts", acceptCnt - acc0, 3);
        applyStimulus(0, 0, '0, 0, 2'd0, '0, 1, 0);
        busyCycles = 0;
        for (int i = 0; i < 200; i++) begin
            idle(1);
            if (!busy) break;
            busyCycles++;
        end
        checkOutput("t4_busy_len", busyCycles, 65);
        checkOutput("t4_err_rdy", {err, dinRdy}, 2'b11);
        checkOutput("t4_b0", b0, 12'h0A0);

        // In-flight limit with F_VOUT held low.
        acc0 = acceptCnt;
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, NB'(12'h501 + i), 0, 2'd0, '0, 0, 0);
        checkOutput("t6_limit_accepts", acceptCnt - acc0, 4);
        checkOutput("t6_limit_rdy", dinRdy, 0);

        // Reset in the middle of a drain.
        applyStimulus(0, 0, '0, 0, 2'd0, '0, 1, 0);
        idle(2);
        checkOutput("t6_drain_busy", busy, 1);
        applyStimulus(1, 0, '0, 0, 2'd0, '0, 0, 0);
        checkOutput("t6_rdy_in_reset", dinRdy, 0);
        idle(1);
        checkOutput("t6_rst_coefs", {b0, b1, a1, fDin}, 0);
        checkOutput("t6_rst_flags", {fVin, fltClr, busy, err}, 0);
        checkOutput("t6_rst_swapcnt", swapCnt, 0);
        checkOutput("t6_rst_rdy", dinRdy, 1);

        // F_VOUT with nothing in flight.
        applyStimulus(0, 0, '0, 0, 2'd0, '0, 0, 1);
        idle(1);
        checkOutput("t6_underflow_err", {err, dinRdy}, 2'b11);
        acc0 = acceptCnt;
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, NB'(12'h601 + i), 0, 2'd0, '0, 0, 0);
        checkOutput("t6_underflow_accepts", acceptCnt - acc0, 4);
        idle(3);
        checkOutput("final_samples_left", sampQ.size(), 0);
        checkOutput("final_swaps_left", coefQ.size(), 0);
        checkOutput("final_fltclr", fltCnt, 1);
        checkOutput("final_swapcnt", swapCnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/iir_cfg_ctrl.md
Name: iir_cfg_ctrl

Overview:
- Sequencer and configurator in front of the 12-bit first-order IIR filter (b0, b1, a1 coefficients, DIN/VIN in, DOUT/VOUT out).
- Holds shadow and active coefficient banks, gates the sample stream into the filter, and counts samples in flight.
- On a commit it drains the filter and swaps coefficients atomically, so no sample is ever processed with mixed coefficients.
- It can also pulse a filter-state clear after the swap.

Parameters:
- NB, 12, data and coefficient width.
- MAX_INFL, 4, maximum samples in flight inside the filter.
- DRAIN_TO, 64, drain timeout in cycles.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- CFG_WE  in  1  shadow-register write strobe.
- CFG_ADDR  in  2  0 = b0, 1 = b1, 2 = a1, 3 = ctrl (bit0 = CLR_EN).
- CFG_DATA  in  NB  write data.
- CFG_COMMIT  in  1  request a shadow-to-active swap (single-cycle pulse).
- DIN  in  NB  upstream sample.
- VIN  in  1  upstream valid.
- DIN_RDY  out  1  upstream ready (combinational).
- F_DIN  out  NB  sample to the filter (registered).
- F_VIN  out  1  valid to the filter (registered).
- B0  out  NB  active b0.
- B1  out  NB  active b1.
- A1  out  NB  active a1.
- F_VOUT  in  1  filter output valid, used for in-flight tracking.
- FLT_CLR  out  1  single-cycle filter-state clear.
- BUSY  out  1  high when state is not RUN.
- ERR  out  1  sticky error flag.
- SWAP_CNT  out  8  completed swaps, wraps from 255 to 0.

Behaviour:
- Reset (synchronous, RST=1):
  - All outputs 0; shadow and active banks 0; CLR_EN = 0.
  - In-flight count 0, pending flag 0, timeout counter 0, state RUN.
  - Reset mid-drain or mid-swap aborts the operation: active bank goes to 0 and the pending swap is lost.
- Ready: DIN_RDY = (state == RUN) and (infl < MAX_INFL) and not RST.
- Accept: a sample is accepted when VIN & DIN_RDY.
  - Next cycle F_VIN = 1 and F_DIN = DIN, giving 1 cycle latency.
  - Otherwise F_VIN = 0 and F_DIN holds its value.
- In-flight counter, width clog2(MAX_INFL+1):
  - Increments on F_VIN = 1 and decrements on F_VOUT = 1; both in the same cycle leaves it unchanged.
  - F_VOUT with infl = 0: counter stays 0 and ERR is set.
- Shadow writes: CFG_WE writes the shadow register at CFG_ADDR in any state.
  - Writes do not change B0/B1/A1 until a swap.
  - CFG_WE and CFG_COMMIT in the same cycle: the write is included in that commit.
- FSM, states RUN, DRAIN, SWAP, CLEAR:
  - RUN: CFG_COMMIT or pending → DRAIN and clear pending. BUSY = 0.
  - DRAIN: DIN_RDY = 0; timeout counter increments each cycle.
    - Counter includes the F_VIN still outstanding from the last accept cycle.
    - infl == 0 and F_VIN == 0 → SWAP.
    - Timeout counter reaches DRAIN_TO−1 → SWAP anyway and set ERR.
  - SWAP (1 cycle):
    - B0/B1/A1 ← shadow contents as of this cycle; SWAP_CNT increments.
    - Timeout counter resets; in-flight counter forced to 0.
    - Next state is CLEAR if CLR_EN, else RUN.
  - CLEAR (1 cycle): FLT_CLR = 1, then → RUN.
- Commit during DRAIN, SWAP or CLEAR sets pending; after returning to RUN a second swap begins on the next cycle.
- ERR is cleared only by RST.
- Arithmetic: SWAP_CNT is 8-bit modular; coefficients are pass-through with no arithmetic.

Test Plan:
1. Reset, then write b0 = 0x100, b1 = 0x080, a1 = 0xF00 and commit with the filter idle → DRAIN lasts 1 cycle, SWAP next; B0 = 0x100, B1 = 0x080, A1 = 0xF00; SWAP_CNT = 1; BUSY high for 2 cycles; FLT_CLR never asserted.
2. Stream continuous VIN with a filter model of 2-cycle latency, commit mid-stream → DIN_RDY drops the cycle after the commit; B0/B1/A1 change only after the last F_VOUT; no F_VIN high while in DRAIN/SWAP; samples are not lost or duplicated, with an input/output count match of 20/20.
3. Set CLR_EN = 1 (addr 3, data 1), then commit → exactly one FLT_CLR pulse, in the cycle after SWAP; DIN_RDY returns to 1 the cycle after that.
4. Hold F_VOUT low with 3 samples in flight, then commit → swap forced after 64 DRAIN cycles; ERR = 1; infl = 0; streaming resumes.
5. Commit, then a second commit and a write b0 = 0x055 during DRAIN → the first swap takes the shadow as of SWAP (b0 = 0x055); a second swap follows; SWAP_CNT advances by 2.
6. VIN held high with F_VOUT low → DIN_RDY falls after 4 accepts. Separately, pulse F_VOUT at infl = 0 → ERR = 1 and the counter stays 0. Separately, assert RST during DRAIN → all outputs 0 next cycle; state RUN.
